adc_serial_responder: RTL

Synthesizable serial-ADC responder: the slave end of the 3-wire ADC link (adc_cs, adc_clk, adc_so) that loctag masters when reading its RF-detector ADC. It oversamples the master's chip-select and serial clock on the 50 MHz system clock and shifts out ADC081S-style frames: leading zeros, one sample MSB-first, then trailing zeros. Intended for a second iCE40 acting as a hardware-in-loop ADC stand-in, and as the bench-side ADC model for loctag.

---
 rtl/adc_serial_responder_if.sv | 32 +++
 rtl/adc_serial_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_responder_if.sv
// ADC serial link plus sample hand-off bundle shared by the responder and whatever feeds or masters it.
interface adc_serial_responder_if #(
    parameter int DATA_BITS = 8
);
    logic                 adc_cs;
    logic                 adc_clk;
    logic                 adc_so;
    logic                 adc_so_oe;
    logic [DATA_BITS-1:0] sample_data;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output adc_cs,
        output adc_clk,
        output sample_data,
        output sample_valid,
        input  adc_so,
        input  adc_so_oe,
        input  sample_ready
    );

    modport slave (
        input  adc_cs,
        input  adc_clk,
        input  sample_data,
        input  sample_valid,
        output adc_so,
        output adc_so_oe,
        output sample_ready
    );
endinterface

// File: rtl/adc_serial_responder.sv
// Serial ADC responder: oversamples adc_cs/adc_clk and shifts out {lead zeros, sample, trail zeros} MSB-first.
// Define ADC_RESPONDER_RAMP_EN to serve an internal wrapping ramp counter instead of the holding buffer.
module adc_serial_responder #(
    parameter int DATA_BITS   = 8,
    parameter int LEAD_ZEROS  = 3,
    parameter int TRAIL_ZEROS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_serial_responder_if.slave link,
    output logic                  sample_stale,
    output logic                  frame_done,
    output logic                  frame_abort
);
    // state | meaning
    // IDLE  | deselected, pad released, waiting for cs fall
    // SHIFT | selected, driving word bit bits_left
    // DONE  | all bits shifted, driving 0 until cs rises

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS + TRAIL_ZEROS;
    localparam int IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_d;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   cs_prev;
    logic                   sclk_prev;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sclk_fall;

    logic [FRAME_BITS-1:0]  word;
    logic [FRAME_BITS-1:0]  word_d;
    logic [IDX_W-1:0]       bits_left;
    logic [IDX_W-1:0]       bits_d;
    logic                   load;
    logic                   use_buf;
    logic [DATA_BITS-1:0]   load_sample;

    logic                   so_q;
    logic                   oe_q;
    logic                   so_d;
    logic                   oe_d;
    logic                   stale_d;
    logic                   done_d;
    logic                   abort_d;

    // Idle-high reset of the chains means a low pin after reset reads as a fall, which IDLE ignores for adc_clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], link.adc_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], link.adc_clk};
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_fall   = cs_prev & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise   = ~cs_prev & cs_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];

`ifdef ADC_RESPONDER_RAMP_EN
    logic [DATA_BITS-1:0] ramp_cnt;
    logic                 unused_sample_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ramp_cnt <= '0;
        end else if (load) begin
            ramp_cnt <= ramp_cnt + DATA_BITS'(1);
        end
    end

    assign load_sample       = ramp_cnt;
    assign use_buf           = 1'b1;
    assign link.sample_ready = 1'b0;
    assign unused_sample_in  = ^{link.sample_data, link.sample_valid};
`else
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_full;
    logic [DATA_BITS-1:0] last_sample;
    logic                 buf_write;

    assign buf_write = link.sample_valid & ~buf_full;

    // A write can only land while empty, so it never collides with the load draining a full buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_data    <= '0;
            buf_full    <= 1'b0;
            last_sample <= '0;
        end else begin
            if (buf_write) begin
                buf_data <= link.sample_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            if (load && buf_full) begin
                last_sample <= buf_data;
            end
        end
    end

    assign load_sample       = buf_full ? buf_data : last_sample;
    assign use_buf           = buf_full;
    assign link.sample_ready = ~buf_full;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            word         <= '0;
            bits_left    <= '0;
            so_q         <= 1'b0;
            oe_q         <= 1'b0;
            sample_stale <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            state        <= state_d;
            word         <= word_d;
            bits_left    <= bits_d;
            so_q         <= so_d;
            oe_q         <= oe_d;
            sample_stale <= stale_d;
            frame_done   <= done_d;
            frame_abort  <= abort_d;
        end
    end

    // bits_left counts down to the terminal bit; a cs fall wins over a same-cycle clock fall by construction.
    always_comb begin
        state_d = state;
        word_d  = word;
        bits_d  = bits_left;
        load    = 1'b0;
        stale_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    load    = 1'b1;
                    stale_d = ~use_buf;
                    word_d  = FRAME_BITS'(load_sample) << TRAIL_ZEROS;
                    bits_d  = LAST_IDX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    if (bits_left == '0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        bits_d = bits_left - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pad values are decoded from the next state so they leave a flop in the same cycle the state changes.
    always_comb begin
        so_d = 1'b0;
        oe_d = 1'b0;
        unique case (state_d)
            SHIFT: begin
                so_d = word_d[bits_d];
                oe_d = 1'b1;
            end
            DONE: begin
                oe_d = 1'b1;
            end
            default: begin
                so_d = 1'b0;
                oe_d = 1'b0;
            end
        endcase
    end

    assign link.adc_so    = so_q;
    assign link.adc_so_oe = oe_q;
endmodule
